// File: rtl/score_keeper.sv
// score_keeper: goal counting, serve pause and game-over freeze for the pong
// game. Takes level goal flags from the ball-physics block and feeds the
// scores to game_fsm and the score display. A serve pause parks the ball
// after every goal and after each game start.
module score_keeper #(
    parameter int SCORE_W      = 4,   // width of each score output
    parameter int WIN_SCORE    = 9,   // winning score, must be < 2**SCORE_W
    parameter int SERVE_FRAMES = 60   // frame ticks of ball hold per serve, >= 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               game_rst_i,
    input  logic               game_en_i,
    input  logic               frame_tick_i,
    input  logic               p_goal_i,
    input  logic               e_goal_i,
    output logic [SCORE_W-1:0] p_score_o,
    output logic [SCORE_W-1:0] e_score_o,
    output logic               ball_hold_o,
    output logic               serve_dir_o,
    output logic               point_o
);

    // The counter must hold 0..SERVE_FRAMES-1; one extra value of headroom
    // keeps the width sensible when SERVE_FRAMES is a power of two.
    localparam int CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES + 1) : 1;

    localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);
    localparam logic [CNT_W-1:0]   LAST_FRAME = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,   // waiting for game_en_i, ball parked
        ST_SERVE,  // serve pause, counting frame ticks
        ST_PLAY,   // rally in progress, goals credited
        ST_OVER    // someone reached WIN_SCORE, scores frozen
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] serve_cnt_q;
    logic             p_goal_q;
    logic             e_goal_q;

    logic             p_edge;
    logic             e_edge;
    logic [SCORE_W-1:0] p_inc;
    logic [SCORE_W-1:0] e_inc;
    logic             p_wins;
    logic             e_wins;

    // Delay the goal levels by one cycle so a long-held goal counts once.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state is assigned with <= so every register samples
        // the pre-edge values; blocking = here would create order-dependent
        // races between always_ff blocks.
        if (rst_i) begin
            p_goal_q <= 1'b0;
            e_goal_q <= 1'b0;
        end else begin
            p_goal_q <= p_goal_i;
            e_goal_q <= e_goal_i;
        end
    end

    // Rising-edge detection and the saturating next-score candidates.
    always_comb begin
        // NOTE: every signal gets a default at the top of always_comb so no
        // path leaves it unassigned and no latch is inferred.
        p_edge = 1'b0;
        e_edge = 1'b0;
        p_inc  = p_score_o;
        e_inc  = e_score_o;

        p_edge = p_goal_i & ~p_goal_q;
        e_edge = e_goal_i & ~e_goal_q;

        // Scores survive a game_en_i drop, so a re-armed game without
        // game_rst_i may already sit at WIN_SCORE: clamp instead of wrapping.
        if (p_score_o < WIN_VAL) begin
            p_inc = p_score_o + SCORE_ONE;
        end else begin
            p_inc = WIN_VAL;
        end

        if (e_score_o < WIN_VAL) begin
            e_inc = e_score_o + SCORE_ONE;
        end else begin
            e_inc = WIN_VAL;
        end
    end

    assign p_wins = (p_inc == WIN_VAL);
    assign e_wins = (e_inc == WIN_VAL);

    // Game state machine with registered scores, hold, serve direction and
    // point pulse. Priority: rst_i, game_rst_i, game_en_i low, then state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            serve_cnt_q <= '0;
            p_score_o   <= '0;
            e_score_o   <= '0;
            ball_hold_o <= 1'b1;
            serve_dir_o <= 1'b0;
            point_o     <= 1'b0;
        end else begin
            // point_o is a single-cycle pulse unless a credit reasserts it.
            point_o     <= 1'b0;
            // Hold follows the state one cycle late: it drops the cycle after
            // PLAY is entered and rises the cycle after a goal leaves PLAY.
            ball_hold_o <= (state_q != ST_PLAY);

            if (game_rst_i) begin
                state_q     <= ST_IDLE;
                serve_cnt_q <= '0;
                p_score_o   <= '0;
                e_score_o   <= '0;
                serve_dir_o <= 1'b0;
            end else if (!game_en_i) begin
                // Scores are kept so the display still shows the last game.
                state_q <= ST_IDLE;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        state_q     <= ST_SERVE;
                        serve_cnt_q <= '0;
                    end

                    ST_SERVE: begin
                        // Goal edges are deliberately ignored while serving.
                        if (frame_tick_i) begin
                            if (serve_cnt_q == LAST_FRAME) begin
                                state_q     <= ST_PLAY;
                                serve_cnt_q <= '0;
                            end else begin
                                serve_cnt_q <= serve_cnt_q + CNT_ONE;
                            end
                        end
                    end

                    ST_PLAY: begin
                        // Player goal wins a tie; a simultaneous enemy edge is
                        // dropped, not deferred.
                        if (p_edge) begin
                            p_score_o   <= p_inc;
                            point_o     <= 1'b1;
                            serve_dir_o <= 1'b1;
                            serve_cnt_q <= '0;
                            state_q     <= p_wins ? ST_OVER : ST_SERVE;
                        end else if (e_edge) begin
                            e_score_o   <= e_inc;
                            point_o     <= 1'b1;
                            serve_dir_o <= 1'b0;
                            serve_cnt_q <= '0;
                            state_q     <= e_wins ? ST_OVER : ST_SERVE;
                        end
                    end

                    ST_OVER: begin
                        // Frozen until game_en_i drops.
                        state_q <= ST_OVER;
                    end

                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: directed scenarios followed by a
// randomized run, every cycle compared against a behavioural game model.
module tb_score_keeper;

    localparam int SCORE_W      = 4;
    localparam int WIN_SCORE    = 9;
    localparam int SERVE_FRAMES = 3;

    logic               clk_i = 1'b0;
    logic               rst_i = 1'b1;
    logic               game_rst_i = 1'b0;
    logic               game_en_i = 1'b0;
    logic               frame_tick_i = 1'b0;
    logic               p_goal_i = 1'b0;
    logic               e_goal_i = 1'b0;
    logic [SCORE_W-1:0] p_score_o;
    logic [SCORE_W-1:0] e_score_o;
    logic               ball_hold_o;
    logic               serve_dir_o;
    logic               point_o;

    int checks   = 0;
    int failures = 0;

    score_keeper #(
        .SCORE_W     (SCORE_W),
        .WIN_SCORE   (WIN_SCORE),
        .SERVE_FRAMES(SERVE_FRAMES)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .game_rst_i  (game_rst_i),
        .game_en_i   (game_en_i),
        .frame_tick_i(frame_tick_i),
        .p_goal_i    (p_goal_i),
        .e_goal_i    (e_goal_i),
        .p_score_o   (p_score_o),
        .e_score_o   (e_score_o),
        .ball_hold_o (ball_hold_o),
        .serve_dir_o (serve_dir_o),
        .point_o     (point_o)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural model: the game described as phases and a countdown of
    // remaining serve frames.
    typedef enum int {M_IDLE, M_SERVE, M_RALLY, M_OVER} phase_t;

    phase_t m_phase  = M_IDLE;
    int     m_left   = 0;
    int     m_p      = 0;
    int     m_e      = 0;
    int     m_dir    = 0;
    int     m_point  = 0;
    int     m_hold   = 1;
    bit     m_prev_p = 1'b0;
    bit     m_prev_e = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Award one point to a side; returns the game to serving or ends it.
    task automatic model_credit(input bit player);
        int s;
        if (player) begin
            m_p   = (m_p + 1 > WIN_SCORE) ? WIN_SCORE : m_p + 1;
            s     = m_p;
            m_dir = 1;
        end else begin
            m_e   = (m_e + 1 > WIN_SCORE) ? WIN_SCORE : m_e + 1;
            s     = m_e;
            m_dir = 0;
        end
        m_point = 1;
        m_left  = SERVE_FRAMES;
        m_phase = (s == WIN_SCORE) ? M_OVER : M_SERVE;
    endtask

    // Advance the model across one clock edge using the current inputs.
    task automatic model_step();
        bit p_rise;
        bit e_rise;
        int next_hold;
        p_rise = p_goal_i && !m_prev_p;
        e_rise = e_goal_i && !m_prev_e;
        if (rst_i) begin
            m_phase  = M_IDLE;
            m_left   = 0;
            m_p      = 0;
            m_e      = 0;
            m_dir    = 0;
            m_point  = 0;
            m_hold   = 1;
            m_prev_p = 1'b0;
            m_prev_e = 1'b0;
            return;
        end
        next_hold = (m_phase != M_RALLY) ? 1 : 0;
        m_point   = 0;
        if (game_rst_i) begin
            m_p     = 0;
            m_e     = 0;
            m_dir   = 0;
            m_left  = 0;
            m_phase = M_IDLE;
        end else if (!game_en_i) begin
            m_phase = M_IDLE;
        end else begin
            case (m_phase)
                M_IDLE: begin
                    m_phase = M_SERVE;
                    m_left  = SERVE_FRAMES;
                end
                M_SERVE: begin
                    if (frame_tick_i) begin
                        m_left--;
                        if (m_left == 0) m_phase = M_RALLY;
                    end
                end
                M_RALLY: begin
                    if (p_rise) model_credit(1'b1);
                    else if (e_rise) model_credit(1'b0);
                end
                default: ;
            endcase
        end
        m_prev_p = p_goal_i;
        m_prev_e = e_goal_i;
        m_hold   = next_hold;
    endtask

    // One clock: model follows the edge, outputs are compared 1 time unit later.
    task automatic step();
        @(posedge clk_i);
        model_step();
        #1;
        check("p_score", p_score_o, m_p);
        check("e_score", e_score_o, m_e);
        check("ball_hold", ball_hold_o, m_hold);
        check("serve_dir", serve_dir_o, m_dir);
        check("point", point_o, m_point);
    endtask

    // Leave IDLE (if needed) and run a full serve pause of frame ticks.
    task automatic serve_out();
        step();
        for (int i = 0; i < SERVE_FRAMES; i++) begin
            frame_tick_i = 1'b1;
            step();
            frame_tick_i = 1'b0;
            step();
        end
    endtask

    task automatic p_point();
        p_goal_i = 1'b1;
        step();
        p_goal_i = 1'b0;
        step();
    endtask

    task automatic e_point();
        e_goal_i = 1'b1;
        step();
        e_goal_i = 1'b0;
        step();
    endtask

    initial begin
        int pulses;

        // 1: reset, then a 3-tick serve pause.
        rst_i = 1'b1;
        step();
        step();
        check("t1_reset_p", p_score_o, 0);
        check("t1_reset_hold", ball_hold_o, 1);
        check("t1_reset_point", point_o, 0);
        rst_i     = 1'b0;
        game_en_i = 1'b1;
        step();
        step();
        for (int i = 0; i < 2; i++) begin
            frame_tick_i = 1'b1;
            step();
            frame_tick_i = 1'b0;
            step();
        end
        check("t1_hold_after_2_ticks", ball_hold_o, 1);
        frame_tick_i = 1'b1;
        step();
        frame_tick_i = 1'b0;
        step();
        check("t1_hold_in_play", ball_hold_o, 0);
        check("t1_scores_zero", {p_score_o, e_score_o}, 0);

        // 2: player goal held for 50 cycles counts once.
        pulses   = 0;
        p_goal_i = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            if (point_o === 1'b1) pulses++;
        end
        p_goal_i = 1'b0;
        step();
        check("t2_point_pulses", pulses, 1);
        check("t2_p_score", p_score_o, 1);
        check("t2_serve_dir", serve_dir_o, 1);
        check("t2_hold", ball_hold_o, 1);

        // 3: simultaneous goals, player has priority.
        serve_out();
        p_goal_i = 1'b1;
        e_goal_i = 1'b1;
        step();
        p_goal_i = 1'b0;
        e_goal_i = 1'b0;
        step();
        check("t3_p_score", p_score_o, 2);
        check("t3_e_score", e_score_o, 0);

        // 4: climb to 8, win at 9, goals ignored in OVER, disable keeps scores.
        for (int i = 0; i < 6; i++) begin
            serve_out();
            p_point();
        end
        check("t4_p_score_8", p_score_o, 8);
        serve_out();
        p_point();
        check("t4_p_score_9", p_score_o, 9);
        serve_out();
        p_point();
        e_point();
        check("t4_over_p", p_score_o, 9);
        check("t4_over_e", e_score_o, 0);
        check("t4_over_hold", ball_hold_o, 1);
        game_en_i = 1'b0;
        step();
        step();
        check("t4_idle_p", p_score_o, 9);
        check("t4_idle_hold", ball_hold_o, 1);

        // 5: game_rst_i beats a goal edge in PLAY.
        game_rst_i = 1'b1;
        step();
        game_rst_i = 1'b0;
        game_en_i  = 1'b1;
        serve_out();
        check("t5_in_play_hold", ball_hold_o, 0);
        e_point();
        check("t5_e_score", e_score_o, 1);
        check("t5_serve_dir", serve_dir_o, 0);
        serve_out();
        p_goal_i   = 1'b1;
        game_rst_i = 1'b1;
        step();
        check("t5_rst_p", p_score_o, 0);
        check("t5_rst_e", e_score_o, 0);
        check("t5_rst_point", point_o, 0);
        p_goal_i   = 1'b0;
        game_rst_i = 1'b0;
        step();
        step();
        check("t5_new_serve_hold", ball_hold_o, 1);
        serve_out();
        check("t5_replay_hold", ball_hold_o, 0);

        // 6: goal during SERVE ignored, then rst_i mid-SERVE.
        e_point();
        p_point();
        check("t6_serve_goal_p", p_score_o, 0);
        frame_tick_i = 1'b1;
        step();
        frame_tick_i = 1'b0;
        rst_i = 1'b1;
        step();
        check("t6_rst_e", e_score_o, 0);
        check("t6_rst_hold", ball_hold_o, 1);
        check("t6_rst_dir", serve_dir_o, 0);
        rst_i = 1'b0;
        step();

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            frame_tick_i = ($urandom_range(2) == 0);
            if ($urandom_range(5) == 0) p_goal_i = ~p_goal_i;
            if ($urandom_range(5) == 0) e_goal_i = ~e_goal_i;
            game_rst_i = ($urandom_range(199) == 0);
            if (game_en_i) game_en_i = ($urandom_range(149) != 0);
            else           game_en_i = ($urandom_range(3) == 0);
            rst_i = ($urandom_range(999) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
